// File: rtl/cnt_pkg.sv
// Shared defaults and parameter checks for the cascaded digit counter.
// The optional parallel-load path is enabled with the CNT_LOAD_EN macro.
package cnt_pkg;

   localparam int CNT_DIGITS = 4;
   localparam int CNT_MOD    = 10;
   localparam int CNT_W      = 4;

   // A digit of w bits must be able to hold every value 0..mod-1.
   function automatic bit digit_width_ok(input int w, input int mod);
      return (mod >= 2) && (w >= 1) && (w < 31) && ((1 << w) >= mod);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One modulo-MOD digit with up/down stepping, clear and terminal decode.
// Parallel load ports exist only when CNT_LOAD_EN is defined.
module bcd_digit
   import cnt_pkg::*;
#(
   parameter int MOD = CNT_MOD,
   parameter int W   = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         step,
   input  logic         up,
`ifdef CNT_LOAD_EN
   input  logic         load,
   input  logic [W-1:0] load_val,
`endif
   output logic [W-1:0] value,
   output logic         co
);

   localparam logic [W-1:0] TOP = W'(MOD - 1);

   logic [W-1:0] value_q, value_d;

   // Values above TOP are never terminal and snap back into range on a step.
   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = '0;
      end
`ifdef CNT_LOAD_EN
      else if (load) begin
         value_d = (load_val > TOP) ? TOP : load_val;
      end
`endif
      else if (step) begin
         if (up) begin
            value_d = (value_q >= TOP) ? '0 : value_q + 1'b1;
         end else begin
            value_d = ((value_q == '0) || (value_q > TOP)) ? TOP : value_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign co    = up ? (value_q == TOP) : (value_q == '0);

endmodule

// File: rtl/bcd_counter_chain.sv
// Cascaded modulo-MOD up/down counter with per-digit carry, terminal flag and wrap pulse.
// Defining CNT_LOAD_EN adds the load/load_val parallel-load ports.
module bcd_counter_chain
   import cnt_pkg::*;
#(
   parameter int DIGITS = CNT_DIGITS,
   parameter int MOD    = CNT_MOD,
   parameter int W      = CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  clr,
`ifdef CNT_LOAD_EN
   input  logic                  load,
   input  logic [DIGITS*W-1:0]   load_val,
`endif
   output logic [DIGITS*W-1:0]   count,
   output logic [DIGITS-1:0]     co,
   output logic                  tc,
   output logic                  wrap
);

   if (!digit_width_ok(W, MOD) || (DIGITS < 1)) begin : g_bad_params
      $error("bcd_counter_chain: need DIGITS>=1 and 2 <= MOD <= 2**W");
   end

   logic [DIGITS-1:0] step;
   logic              wrap_q, wrap_d;
   logic              load_act;

`ifdef CNT_LOAD_EN
   assign load_act = load;
`else
   assign load_act = 1'b0;
`endif

   // Ripple decoded from registered digits, so every digit moves on the same edge.
   assign step[0] = en;
   for (genvar g = 1; g < DIGITS; g++) begin : g_step
      assign step[g] = step[g-1] & co[g-1];
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit #(
         .MOD (MOD),
         .W   (W)
      ) u_digit (
         .clk      (clk),
         .rst      (rst),
         .clr      (clr),
         .step     (step[g]),
         .up       (up),
`ifdef CNT_LOAD_EN
         .load     (load),
         .load_val (load_val[g*W +: W]),
`endif
         .value    (count[g*W +: W]),
         .co       (co[g])
      );
   end

   assign tc = &co;

   always_comb begin
      wrap_d = en & tc;
      if (clr || load_act) begin
         wrap_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrap = wrap_q;

endmodule
